// File: rtl/instr_fetch_sequencer.sv
// instr_fetch_sequencer: fetches 16-bit instruction words (a second word for group 5),
// classifies the first word and hands complete instructions to decode; owns the PC.
module instr_fetch_sequencer #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [15:0]           mem_rdata,
   input  logic                  mem_ack,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [15:0]           instr_hi,
   output logic [15:0]           instr_lo,
   output logic [2:0]            instr_grp,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc
);
   typedef enum logic [1:0] {FETCH_HI, FETCH_LO, HOLD, DISCARD} state_t;
   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d, redir_q, redir_d, ipc_q, ipc_d;
   logic                  req_q, req_d, valid_q, valid_d;
   logic [15:0]           hi_q, hi_d, lo_q, lo_d;
   logic [2:0]            grp_q, grp_d, grp_w;

   function automatic logic [2:0] classify(input logic [15:0] w);
      return !w[15] ? 3'd1 : !w[14] ? 3'd2 : w[15:12] == 4'b1100 ? 3'd3 :
             w[15:12] == 4'b1101 ? 3'd4 : w[15:10] == 6'b111000 ? 3'd5 : 3'd0;
   endfunction

   assign grp_w = classify(mem_rdata);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      redir_d = redir_q;
      req_d   = req_q;
      valid_d = valid_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      grp_d   = grp_q;
      ipc_d   = ipc_q;
      case (state_q)
         FETCH_HI, FETCH_LO: begin
            if (redirect_valid) begin
               // an outstanding request cannot be withdrawn, so its data is drained in DISCARD
               if (req_q && !mem_ack) begin
                  redir_d = redirect_pc;
                  state_d = DISCARD;
               end else begin
                  pc_d    = redirect_pc;
                  state_d = FETCH_HI;
                  req_d   = !req_q;
               end
            end else if (!req_q) begin
               req_d = 1'b1;
            end else if (mem_ack) begin
               pc_d = pc_q + 1'b1;
               if (state_q == FETCH_HI) begin
                  hi_d  = mem_rdata;
                  ipc_d = pc_q;
                  grp_d = grp_w;
                  lo_d  = '0;
               end else begin
                  lo_d = mem_rdata;
               end
               if (state_q == FETCH_HI && grp_w == 3'd5) begin
                  state_d = FETCH_LO;
               end else begin
                  state_d = HOLD;
                  req_d   = 1'b0;
                  valid_d = 1'b1;
               end
            end
         end
         HOLD: begin
            if (redirect_valid || instr_ready) begin
               state_d = FETCH_HI;
               valid_d = 1'b0;
               req_d   = 1'b1;
               pc_d    = redirect_valid ? redirect_pc : pc_q;
            end
         end
         DISCARD: begin
            if (redirect_valid) redir_d = redirect_pc;
            if (mem_ack) begin
               state_d = FETCH_HI;
               pc_d    = redirect_valid ? redirect_pc : redir_q;
            end
         end
         default: state_d = FETCH_HI;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH_HI;
         pc_q    <= RESET_PC;
         redir_q <= '0;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         grp_q   <= '0;
         ipc_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         redir_q <= redir_d;
         req_q   <= req_d;
         valid_q <= valid_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         grp_q   <= grp_d;
         ipc_q   <= ipc_d;
      end
   end

   assign mem_req     = req_q;
   assign mem_addr    = pc_q;
   assign instr_valid = valid_q;
   assign instr_hi    = hi_q;
   assign instr_lo    = lo_q;
   assign instr_grp   = grp_q;
   assign instr_pc    = ipc_q;
endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// tb_instr_fetch_sequencer: random-latency memory, directed scenarios plus random
// ready/redirect traffic, checked against an instruction-stream model of the program.
module tb_instr_fetch_sequencer;
   logic        clk, rst_n, mem_req, mem_ack, instr_valid, instr_ready, redirect_valid;
   logic [15:0] mem_addr, mem_rdata, instr_hi, instr_lo, instr_pc, redirect_pc;
   logic [2:0]  instr_grp;

   instr_fetch_sequencer #(.ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut (
      .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .instr_hi(instr_hi), .instr_lo(instr_lo),
      .instr_grp(instr_grp), .instr_pc(instr_pc), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc));

   logic [15:0] mem [65536];
   int          n_chk = 0, n_fail = 0, n_xfer = 0;
   int          wait_lo = 0, wait_hi = 0;
   logic        junk_en = 1'b1;
   logic [15:0] exp_pc = 16'h0000;
   logic [15:0] last_hi, last_lo, last_pc;
   logic [2:0]  last_grp;
   logic [2:0]  got_grp [$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [2:0] grp_of(input logic [15:0] w);
      if (w[15] == 1'b0) return 3'd1;
      if (w[15:14] == 2'b10) return 3'd2;
      if (w[15:12] == 4'b1100) return 3'd3;
      if (w[15:12] == 4'b1101) return 3'd4;
      if (w[15:10] == 6'b111000) return 3'd5;
      return 3'd0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic redirect(input logic [15:0] a);
      redirect_valid = 1'b1;
      redirect_pc    = a;
      step();
      redirect_valid = 1'b0;
   endtask

   task automatic wait_xfers(input int n);
      int t;
      t = n_xfer + n;
      for (int k = 0; k < 300 && n_xfer < t; k++) step();
      chk("xfer_timeout", n_xfer >= t, 1);
   endtask

   // memory: random wait states per request, spurious acks while idle
   initial begin
      bit busy;
      int wcnt;
      busy = 0;
      wcnt = 0;
      mem_ack = 1'b0;
      mem_rdata = 16'h0;
      forever begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (!rst_n) begin
            busy = 0;
         end else if (mem_req) begin
            if (!busy) begin
               busy = 1;
               wcnt = $urandom_range(wait_hi, wait_lo);
            end
            if (wcnt == 0) begin
               mem_ack   = 1'b1;
               mem_rdata = mem[mem_addr];
               busy      = 0;
            end else begin
               wcnt--;
            end
         end
         if (!mem_req && junk_en && $urandom_range(1, 0) == 1) begin
            mem_ack   = 1'b1;
            mem_rdata = 16'($urandom);
         end
      end
   end

   // reference: the next instruction delivered is always the one at exp_pc
   initial begin
      bit          prev_busy;
      logic [15:0] prev_addr, w, nxt;
      logic [2:0]  g;
      prev_busy = 0;
      prev_addr = 16'h0;
      forever begin
         @(negedge clk);
         #1;
         if (!rst_n) begin
            exp_pc    = 16'h0000;
            prev_busy = 0;
         end else begin
            w   = mem[exp_pc];
            nxt = exp_pc + 16'd1;
            g   = grp_of(w);
            if (instr_valid) begin
               chk("out_hi", instr_hi, w);
               chk("out_lo", instr_lo, g == 3'd5 ? mem[nxt] : 16'h0000);
               chk("out_grp", instr_grp, g);
               chk("out_pc", instr_pc, exp_pc);
               chk("no_req_while_valid", mem_req, 0);
            end
            if (prev_busy) begin
               chk("req_held", mem_req, 1);
               chk("addr_stable", mem_addr, prev_addr);
            end
            prev_busy = mem_req && !mem_ack;
            prev_addr = mem_addr;
            if (instr_valid && instr_ready && !redirect_valid) begin
               n_xfer++;
               last_hi  = instr_hi;
               last_lo  = instr_lo;
               last_pc  = instr_pc;
               last_grp = instr_grp;
               got_grp.push_back(instr_grp);
               exp_pc = exp_pc + (g == 3'd5 ? 16'd2 : 16'd1);
            end
            if (redirect_valid) exp_pc = redirect_pc;
         end
      end
   end

   initial begin
      int b, gb;
      logic [15:0] a0;
      for (int i = 0; i < 65536; i++)
         mem[i] = ($urandom_range(3, 0) == 0) ? {6'b111000, 10'($urandom)} : 16'($urandom);
      mem[0] = 16'h1234; mem[1] = 16'h8A5B;
      mem[4] = 16'hE0AB; mem[5] = 16'hCAFE;
      mem[8] = 16'hC123; mem[9] = 16'hD0FF; mem[10] = 16'hF000;
      mem[16'hFFFF] = 16'hE000;
      for (int i = 16'h300; i < 16'h320; i++) mem[i] = 16'h0001;
      rst_n = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0;
      repeat (3) step();
      chk("rst_req", mem_req, 0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_hi", instr_hi, 0);
      chk("rst_lo", instr_lo, 0);
      chk("rst_grp", instr_grp, 0);
      chk("rst_pc", instr_pc, 0);
      rst_n = 1'b1;
      instr_ready = 1'b1;
      step();
      chk("first_req", mem_req, 1);
      chk("first_addr", mem_addr, 16'h0000);
      step();
      chk("first_valid", instr_valid, 1);
      chk("first_hi", instr_hi, 16'h1234);
      chk("first_grp", instr_grp, 1);
      chk("first_pc", instr_pc, 16'h0000);
      chk("first_lo", instr_lo, 16'h0000);
      wait_xfers(2);
      chk("second_hi", last_hi, 16'h8A5B);
      chk("second_grp", last_grp, 2);
      chk("second_pc", last_pc, 16'h0001);
      chk("second_lo", last_lo, 16'h0000);
      redirect(16'h0004);
      wait_xfers(1);
      chk("g5_hi", last_hi, 16'hE0AB);
      chk("g5_lo", last_lo, 16'hCAFE);
      chk("g5_grp", last_grp, 5);
      chk("g5_pc", last_pc, 16'h0004);
      wait_xfers(1);
      chk("g5_next_pc", last_pc, 16'h0006);
      instr_ready = 1'b0;
      redirect(16'h0008);
      for (int k = 0; k < 50 && !instr_valid; k++) step();
      chk("bp_valid_reached", instr_valid, 1);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("bp_valid_held", instr_valid, 1);
         chk("bp_no_req", mem_req, 0);
         chk("bp_hi_stable", instr_hi, 16'hC123);
      end
      gb = got_grp.size();
      instr_ready = 1'b1;
      wait_xfers(3);
      chk("bp_grp0", got_grp[gb], 3);
      chk("bp_grp1", got_grp[gb+1], 4);
      chk("bp_grp2", got_grp[gb+2], 0);
      instr_ready = 1'b0;
      for (int k = 0; k < 50 && !instr_valid; k++) step();
      chk("dis_valid_reached", instr_valid, 1);
      wait_lo = 3; wait_hi = 3;
      instr_ready = 1'b1;
      step();
      chk("dis_req", mem_req, 1);
      a0 = mem_addr;
      redirect(16'h0100);
      chk("dis_addr_kept", mem_addr, a0);
      chk("dis_req_kept", mem_req, 1);
      for (int k = 0; k < 20 && !(mem_req && mem_addr == 16'h0100); k++) step();
      chk("dis_new_addr", mem_addr, 16'h0100);
      wait_xfers(1);
      chk("dis_first_pc", last_pc, 16'h0100);
      wait_lo = 0; wait_hi = 0;
      instr_ready = 1'b0;
      for (int k = 0; k < 50 && !instr_valid; k++) step();
      chk("hr_valid_reached", instr_valid, 1);
      instr_ready = 1'b1;
      b = n_xfer;
      redirect(16'h0200);
      chk("hr_valid_drop", instr_valid, 0);
      chk("hr_no_xfer", n_xfer, b);
      chk("hr_req", mem_req, 1);
      chk("hr_addr", mem_addr, 16'h0200);
      redirect(16'h0300);
      b = n_xfer;
      repeat (30) step();
      chk("throughput", (n_xfer - b) >= 10, 1);
      mem[0] = 16'h5555;
      redirect(16'hFFFF);
      wait_xfers(1);
      chk("wrap_hi", last_hi, 16'hE000);
      chk("wrap_lo", last_lo, 16'h5555);
      chk("wrap_pc", last_pc, 16'hFFFF);
      chk("wrap_grp", last_grp, 5);
      wait_xfers(1);
      chk("wrap_next_pc", last_pc, 16'h0001);
      wait_lo = 3; wait_hi = 3;
      redirect(16'hFFFF);
      for (int k = 0; k < 40 && !(mem_req && mem_addr == 16'h0000); k++) step();
      chk("lo_fetch_reached", mem_req && mem_addr == 16'h0000, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_req", mem_req, 0);
      chk("arst_valid", instr_valid, 0);
      chk("arst_hi", instr_hi, 0);
      chk("arst_lo", instr_lo, 0);
      chk("arst_grp", instr_grp, 0);
      chk("arst_pc", instr_pc, 0);
      repeat (2) step();
      rst_n = 1'b1;
      step();
      chk("restart_req", mem_req, 1);
      chk("restart_addr", mem_addr, 16'h0000);
      wait_xfers(1);
      chk("restart_pc", last_pc, 16'h0000);
      chk("restart_hi", last_hi, 16'h5555);
      wait_lo = 0; wait_hi = 3;
      b = n_xfer;
      for (int k = 0; k < 2000; k++) begin
         instr_ready    = $urandom_range(9, 0) < 7;
         redirect_valid = $urandom_range(99, 0) < 3;
         redirect_pc    = 16'($urandom);
         step();
      end
      redirect_valid = 1'b0;
      instr_ready = 1'b1;
      repeat (20) step();
      chk("random_progress", n_xfer > b + 100, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
